// File: rtl/video_sync_out_pkg.sv
// Shared types and defaults for the video output stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_sync_out_pkg;

    // 640x480@60 timing, used as parameter defaults by video_sync_out.
    localparam int RGB_SIZE_DEF   = 12;
    localparam int HVA_DEF        = 640;
    localparam int HFP_DEF        = 16;
    localparam int HSP_DEF        = 96;
    localparam int HBP_DEF        = 48;
    localparam int VVA_DEF        = 480;
    localparam int VFP_DEF        = 10;
    localparam int VSP_DEF        = 2;
    localparam int VBP_DEF        = 33;
    localparam int FIFO_DEPTH_DEF = 16;

    // Frame coordinates carried alongside every pixel of the core chain.
    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
    } vga_fc_t;

    // Stream-to-display alignment states.
    typedef enum logic [1:0] {
        SEEK = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } sync_state_t;

    // Bits needed to count 0..n-1 (at least 1).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: full is the caller's ready; push while full and pop while empty are ignored.
// Ports: push/din write side, pop/dout read side (dout valid while !empty), full, empty.
module video_pixel_fifo #(
    parameter int DW    = 13,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/video_sync_out.sv
// Last stage of the video chain: buffers the pixel stream and drives VGA sync, de and rgb.
// Latency: all vga_* outputs are registered, one cycle after the counter position they reflect.
// Backpressure: src_rdy = !fifo_full (0 in reset); pixels drain only in active cycles of a locked frame.
// Ports: clk, rst_n (sync, active-low); src_vld/src_rdy/src_fc/src_rgb stream in;
//        vga_hsync/vga_vsync/vga_de/vga_rgb display out; stat_underflow 1-cycle pulse.
module video_sync_out
    import video_sync_out_pkg::*;
#(
    parameter int RGB_SIZE   = RGB_SIZE_DEF,
    parameter int HVA        = HVA_DEF,
    parameter int HFP        = HFP_DEF,
    parameter int HSP        = HSP_DEF,
    parameter int HBP        = HBP_DEF,
    parameter int VVA        = VVA_DEF,
    parameter int VFP        = VFP_DEF,
    parameter int VSP        = VSP_DEF,
    parameter int VBP        = VBP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                src_vld,
    output logic                src_rdy,
    input  vga_fc_t             src_fc,
    input  logic [RGB_SIZE-1:0] src_rgb,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_de,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic                stat_underflow
);
    localparam int HTOT = HVA + HFP + HSP + HBP;
    localparam int VTOT = VVA + VFP + VSP + VBP;
    localparam int HW   = cnt_w(HTOT);
    localparam int VW   = cnt_w(VTOT);
    localparam int DW   = RGB_SIZE + 1;

    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    sync_state_t         state_q, state_d;
    logic                rdy_en_q, rdy_en_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                de_q, de_d;
    logic                uf_q, uf_d;
    logic [RGB_SIZE-1:0] rgb_q, rgb_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0]       fifo_din, fifo_dout;
    logic                active, at_origin, frame_end, head_sof;
    logic [RGB_SIZE-1:0] head_rgb;

    // rdy_en_q holds ready low for the reset cycle itself, then frees it.
    assign src_rdy   = rdy_en_q && !fifo_full;
    assign fifo_push = src_vld && src_rdy;
    assign fifo_din  = {(src_fc.hc == '0) && (src_fc.vc == '0), src_rgb};
    assign head_sof  = fifo_dout[DW-1];
    assign head_rgb  = fifo_dout[RGB_SIZE-1:0];

    video_pixel_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Free-running raster counters, independent of the alignment FSM.
    always_comb begin
        h_cnt_d  = h_cnt_q + HW'(1);
        v_cnt_d  = v_cnt_q;
        rdy_en_d = 1'b1;
        if (h_cnt_q == HW'(HTOT - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VW'(VTOT - 1)) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Timing decode, alignment FSM and next values of the output registers.
    always_comb begin
        active    = (int'(h_cnt_q) < HVA) && (int'(v_cnt_q) < VVA);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        frame_end = (h_cnt_q == HW'(HTOT - 1)) && (v_cnt_q == VW'(VTOT - 1));

        hsync_d  = ((int'(h_cnt_q) >= HVA + HFP) && (int'(h_cnt_q) < HVA + HFP + HSP))
                   ? SYNC_POL : !SYNC_POL;
        vsync_d  = ((int'(v_cnt_q) >= VVA + VFP) && (int'(v_cnt_q) < VVA + VFP + VSP))
                   ? SYNC_POL : !SYNC_POL;
        de_d     = active;
        rgb_d    = '0;
        uf_d     = 1'b0;
        fifo_pop = 1'b0;
        state_d  = state_q;

        case (state_q)
            SEEK: begin
                // Discard everything ahead of the next frame start.
                if (!fifo_empty) begin
                    if (head_sof) state_d  = WAIT;
                    else          fifo_pop = 1'b1;
                end
            end
            WAIT: begin
                if (frame_end) state_d = RUN;
            end
            RUN: begin
                if (active) begin
                    if (fifo_empty) begin
                        uf_d    = 1'b1;
                        state_d = SEEK;
                    end else if (head_sof && !at_origin) begin
                        // Stream is ahead of the display: keep this frame start
                        // for the next display frame.
                        state_d = WAIT;
                    end else begin
                        fifo_pop = 1'b1;
                        rgb_d    = head_rgb;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            state_q  <= SEEK;
            rdy_en_q <= 1'b0;
            hsync_q  <= !SYNC_POL;
            vsync_q  <= !SYNC_POL;
            de_q     <= 1'b0;
            rgb_q    <= '0;
            uf_q     <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            state_q  <= state_d;
            rdy_en_q <= rdy_en_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            rgb_q    <= rgb_d;
            uf_q     <= uf_d;
        end
    end

    assign vga_hsync      = hsync_q;
    assign vga_vsync      = vsync_q;
    assign vga_de         = de_q;
    assign vga_rgb        = rgb_q;
    assign stat_underflow = uf_q;

endmodule

// File: tb/tb_video_sync_out.sv
// Directed bench for video_sync_out on a 12x7 raster (8x4 active) with a 4-deep FIFO.
// Expected sync/de/rgb/underflow per cycle come from the raster position since reset.
// Stream pixels are offered whenever available; acceptance follows src_vld && src_rdy.
module tb_video_sync_out;
    import video_sync_out_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          src_vld;
    logic          src_rdy;
    vga_fc_t       src_fc;
    logic [11:0]   src_rgb;
    logic          vga_hsync, vga_vsync, vga_de;
    logic [11:0]   vga_rgb;
    logic          stat_underflow;

    always #5 clk = ~clk;

    video_sync_out #(
        .RGB_SIZE(12), .HVA(8), .HFP(1), .HSP(2), .HBP(1),
        .VVA(4), .VFP(1), .VSP(1), .VBP(1), .FIFO_DEPTH(4), .SYNC_POL(1'b0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_vld        (src_vld),
        .src_rdy        (src_rdy),
        .src_fc         (src_fc),
        .src_rgb        (src_rgb),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_de         (vga_de),
        .vga_rgb        (vga_rgb),
        .stat_underflow (stat_underflow)
    );

    int total = 0;
    int bad   = 0;
    int k;                      // clock edges since the last reset edge
    int s_h [100];
    int s_v [100];
    int s_rgb [100];
    int s_len, s_idx;
    int lock_frame;             // display frame in which output is expected to start
    int npix;                   // pixels available from lock_frame onwards
    bit fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic drive();
        if (s_idx < s_len) begin
            src_vld   = 1'b1;
            src_fc.hc = 11'(s_h[s_idx]);
            src_fc.vc = 11'(s_v[s_idx]);
            src_rgb   = 12'(s_rgb[s_idx]);
        end else begin
            src_vld = 1'b0;
            src_fc  = '0;
            src_rgb = '0;
        end
    endtask

    task automatic add_px(input int h, input int v, input int rgb);
        s_h[s_len]   = h;
        s_v[s_len]   = v;
        s_rgb[s_len] = rgb;
        s_len++;
    endtask

    task automatic add_frame(input int base);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 8; h++)
                add_px(h, v, base + h + 16 * v);
    endtask

    // g-th displayed pixel: stream frame n carries base 0x100*n.
    function automatic int exp_pix(input int g);
        return 256 * (g / 32) + (g % 32) % 8 + 16 * ((g % 32) / 8);
    endfunction

    task automatic check_cycle();
        int cyc, h, v, fr, g;
        logic e_hs, e_vs, e_de, e_uf;
        logic [11:0] e_rgb;
        cyc   = k - 1;              // outputs show the previous counter position
        h     = cyc % 12;
        v     = (cyc / 12) % 7;
        fr    = cyc / 84;
        e_hs  = !(h >= 9 && h < 11);
        e_vs  = (v != 5);
        e_de  = (h < 8) && (v < 4);
        e_rgb = '0;
        e_uf  = 1'b0;
        if (e_de && fr >= lock_frame) begin
            g = (fr - lock_frame) * 32 + v * 8 + h;
            if (g < npix)       e_rgb = 12'(exp_pix(g));
            else if (g == npix) e_uf  = 1'b1;
        end
        chk("hsync", 32'(vga_hsync), 32'(e_hs));
        chk("vsync", 32'(vga_vsync), 32'(e_vs));
        chk("de", 32'(vga_de), 32'(e_de));
        chk("rgb", 32'(vga_rgb), 32'(e_rgb));
        chk("underflow", 32'(stat_underflow), 32'(e_uf));
        if (k == 1) chk("rdy_after_release", 32'(src_rdy), 32'd1);
    endtask

    task automatic tick();
        fire = src_vld && src_rdy;
        @(posedge clk);
        #1;
        k++;
        if (fire) s_idx++;
        drive();
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        src_vld = 1'b0;
        src_fc  = '0;
        src_rgb = '0;
        s_len   = 0;
        s_idx   = 0;
        @(posedge clk);
        #1;
        k = 0;
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_de", 32'(vga_de), 32'd0);
        chk("rst_rgb", 32'(vga_rgb), 32'd0);
        chk("rst_underflow", 32'(stat_underflow), 32'd0);
        chk("rst_rdy", 32'(src_rdy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: bare timing, no stream; FSM never leaves SEEK so no underflow.
        do_reset();
        lock_frame = 1000; npix = 0;
        drive();
        run(168);

        // 2: lock onto a full frame; FIFO fills to 4 and ready drops while waiting.
        do_reset();
        add_frame(0);
        lock_frame = 1; npix = 32;
        drive();
        run(4);
        chk("rdy_level3", 32'(src_rdy), 32'd1);
        run(1);
        chk("rdy_full", 32'(src_rdy), 32'd0);
        run(164);

        // 3: three pixels mid-frame ahead of the frame start are dropped.
        do_reset();
        add_px(5, 2, 16'h025);
        add_px(6, 2, 16'h026);
        add_px(7, 2, 16'h027);
        add_frame(0);
        lock_frame = 1; npix = 32;
        drive();
        run(169);

        // 4: only 10 pixels: underflow at line 1 pixel 2, then relock on a new frame.
        do_reset();
        add_frame(0);
        s_len = 10;
        lock_frame = 1; npix = 10;
        drive();
        run(169);
        add_frame(0);
        lock_frame = 3; npix = 32;
        drive();
        run(168);

        // 5: two back-to-back frames under continuous valid with ready toggling.
        do_reset();
        add_frame(0);
        add_frame(256);
        lock_frame = 1; npix = 64;
        drive();
        run(5);
        chk("bp_rdy_full", 32'(src_rdy), 32'd0);
        run(248);

        // 6: reset for one cycle at h=3,v=2; stale FIFO contents must not surface.
        do_reset();
        add_frame(0);
        lock_frame = 1; npix = 32;
        drive();
        run(27);
        do_reset();
        lock_frame = 1000; npix = 0;
        drive();
        run(168);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
